// File: rtl/deca_i2c_pkg.sv
// rtl/deca_i2c_pkg.sv - shared constants and FSM state type for the DecaSoc I2C bus arbiter
package deca_i2c_pkg;

  localparam int DECA_I2C_NBUS = 5;

  localparam int I2C0  = 0;
  localparam int CAP   = 1;
  localparam int LIGHT = 2;
  localparam int RHT   = 3;
  localparam int PMON  = 4;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request after ptr, wrapping modulo N
module rr_arbiter #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             valid
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      // wrap at N-1 so indices >= N are never visited
      idx = (idx >= SEL_W'(N - 1)) ? '0 : idx + 1'b1;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - shares one I2C master core between N_BUS buses with rr grant,
// watchdog release of hung owners and a bus-idle guard before re-arbitration
module i2c_bus_arbiter
  import deca_i2c_pkg::*;
#(
  parameter int N_BUS   = DECA_I2C_NBUS,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 50000,
  parameter int GUARD   = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BUS-1:0] i_req,
  output logic [N_BUS-1:0] o_gnt,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_busy,
  output logic             o_timeout,
  input  logic             i_m_scl_o,
  input  logic             i_m_scl_oe,
  input  logic             i_m_sda_o,
  input  logic             i_m_sda_oe,
  output logic             o_m_scl_i,
  output logic             o_m_sda_i,
  output logic [N_BUS-1:0] o_scl_o,
  output logic [N_BUS-1:0] o_scl_oe,
  output logic [N_BUS-1:0] o_sda_o,
  output logic [N_BUS-1:0] o_sda_oe,
  input  logic [N_BUS-1:0] i_scl_i,
  input  logic [N_BUS-1:0] i_sda_i
);

  localparam int CNT_W = $clog2((TIMEOUT > GUARD) ? TIMEOUT : GUARD);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] ptr, pick;
  logic             pick_vld;
  logic             scl_oe_q;
  logic             wd_fire;
  logic             bus_idle;
  logic [N_BUS-1:0] blocked;

  rr_arbiter #(.N(N_BUS), .SEL_W(SEL_W)) u_rr (
    .req   (i_req & ~blocked),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_ARB;
    else       state <= state_nx;
  end

  // cnt is the watchdog while owning and the idle guard while draining
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wd_fire  = 1'b0;
    bus_idle = i_scl_i[o_sel] & i_sda_i[o_sel];
    case (state)
      ST_ARB: begin
        cnt_nx = '0;
        if (pick_vld) state_nx = ST_OWN;
      end
      ST_OWN: begin
        cnt_nx = (i_m_scl_oe != scl_oe_q) ? '0 : cnt + 1'b1;
        if (i_m_scl_oe == scl_oe_q && cnt == CNT_W'(TIMEOUT - 1)) begin
          wd_fire  = 1'b1;
          state_nx = ST_DRAIN;
          cnt_nx   = '0;
        end else if (!i_req[o_sel]) begin
          state_nx = ST_DRAIN;
          cnt_nx   = '0;
        end
      end
      ST_DRAIN: begin
        if (!bus_idle) begin
          cnt_nx = '0;
        end else if (cnt == CNT_W'(GUARD - 1)) begin
          state_nx = ST_ARB;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      ptr       <= SEL_W'(N_BUS - 1);
      o_gnt     <= '0;
      o_sel     <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      scl_oe_q  <= 1'b0;
      blocked   <= '0;
    end else begin
      cnt       <= cnt_nx;
      o_timeout <= wd_fire;
      scl_oe_q  <= i_m_scl_oe;
      // a revoked owner stays ineligible until it lets go of its request
      blocked   <= (blocked & i_req) | (wd_fire ? o_gnt : '0);
      if (state == ST_ARB && pick_vld) begin
        o_gnt  <= N_BUS'(1) << pick;
        o_sel  <= pick;
        o_busy <= 1'b1;
        ptr    <= pick;
      end else if (state == ST_OWN && state_nx == ST_DRAIN) begin
        o_gnt  <= '0;
        o_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    o_scl_o   = '0;
    o_scl_oe  = '0;
    o_sda_o   = '0;
    o_sda_oe  = '0;
    o_m_scl_i = 1'b1;
    o_m_sda_i = 1'b1;
    if (state == ST_OWN) begin
      o_scl_o[o_sel]  = i_m_scl_o;
      o_scl_oe[o_sel] = i_m_scl_oe;
      o_sda_o[o_sel]  = i_m_sda_o;
      o_sda_oe[o_sel] = i_m_sda_oe;
      o_m_scl_i       = i_scl_i[o_sel];
      o_m_sda_i       = i_sda_i[o_sel];
    end
  end

endmodule
